// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter: queues ALU and load results in two small FIFOs and merges them
// round-robin onto the single registered GPR write port, exporting a pending-write mask.
module gpr_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_dst,
    input  logic [W-1:0]  alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_dst,
    input  logic [W-1:0]  mem_data,
    output logic [W-1:0]  sin,
    output logic [AW-1:0] sc,
    output logic          sw,
    output logic [31:0]   pending,
    output logic          idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + W;

    // Index 0 is the ALU source, index 1 the load unit.
    logic [EW-1:0] fifo_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [EW-1:0] in_entry [2];

    logic [1:0]    in_valid, ready, push, pop, not_empty;
    logic          last_mem_q, last_mem_d;
    logic          gnt_alu, gnt_mem;
    logic [EW-1:0] head_entry;
    logic [AW-1:0] head_dst;
    logic          sw_q, sw_d;
    logic [AW-1:0] sc_q, sc_d;
    logic [W-1:0]  sin_q, sin_d;

    assign in_valid    = {mem_valid, alu_valid};
    assign in_entry[0] = {alu_dst, alu_data};
    assign in_entry[1] = {mem_dst, mem_data};

    // Ready comes from occupancy and reset only, so there is no path from valid or pop.
    always_comb begin
        ready     = '0;
        not_empty = '0;
        for (int s = 0; s < 2; s++) begin
            ready[s]     = rstn & (cnt_q[s] != CW'(DEPTH));
            not_empty[s] = (cnt_q[s] != '0);
        end
    end

    assign push      = in_valid & ready;
    assign alu_ready = ready[0];
    assign mem_ready = ready[1];

    assign gnt_alu    = rstn & not_empty[0] & (~not_empty[1] | last_mem_q);
    assign gnt_mem    = rstn & not_empty[1] & ~gnt_alu;
    assign pop        = {gnt_mem, gnt_alu};
    assign head_entry = gnt_alu ? fifo_q[0][rd_ptr_q[0]] : fifo_q[1][rd_ptr_q[1]];
    assign head_dst   = head_entry[EW-1:W];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = push[s] ? wr_ptr_q[s] + PW'(1) : wr_ptr_q[s];
            rd_ptr_d[s] = pop[s] ? rd_ptr_q[s] + PW'(1) : rd_ptr_q[s];
            cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
        last_mem_d = gnt_alu ? 1'b0 : (gnt_mem ? 1'b1 : last_mem_q);
    end

    // A consumed r0 entry clears the port instead of holding the previous write.
    always_comb begin
        sw_d  = 1'b0;
        sc_d  = sc_q;
        sin_d = sin_q;
        if (gnt_alu || gnt_mem) begin
            if (head_dst != '0) begin
                sw_d  = 1'b1;
                sc_d  = head_dst;
                sin_d = head_entry[W-1:0];
            end else begin
                sc_d  = '0;
                sin_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            last_mem_q <= 1'b1;
            sw_q       <= 1'b0;
            sc_q       <= '0;
            sin_q      <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                cnt_q[s]    <= cnt_d[s];
            end
            last_mem_q <= last_mem_d;
            sw_q       <= sw_d;
            sc_q       <= sc_d;
            sin_q      <= sin_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) fifo_q[s][wr_ptr_q[s]] <= in_entry[s];
        end
    end

    // Walk only the occupied slots, starting from each head.
    always_comb begin
        pending = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (CW'(k) < cnt_q[s])
                    pending[fifo_q[s][rd_ptr_q[s] + PW'(k)][EW-1:W]] = 1'b1;
            end
        end
        if (sw_q) pending[sc_q] = 1'b1;
        pending[0] = 1'b0;
        if (!rstn) pending = '0;
    end

    assign sw   = sw_q;
    assign sc   = sc_q;
    assign sin  = sin_q;
    assign idle = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !sw_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter: reset, single write, round-robin,
// r0 suppression, backpressure ordering and mid-operation reset.
module tb_gpr_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int W     = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_dst, mem_dst;
    logic [W-1:0]  alu_data, mem_data;
    logic [W-1:0]  sin;
    logic [AW-1:0] sc;
    logic          sw;
    logic [31:0]   pending;
    logic          idle;

    int checks = 0;
    int errors = 0;

    gpr_wb_arbiter #(.DEPTH(DEPTH), .W(W), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
        .sin(sin), .sc(sc), .sw(sw), .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rstn = 1'b0;
        alu_valid = 1'b1; alu_dst = 5'd3; alu_data = 32'h1234_5678;
        mem_valid = 1'b1; mem_dst = 5'd4; mem_data = 32'h8765_4321;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++; if (sw !== 1'b0) begin $display("FAIL reset_sw got %b exp 0", sw); errors++; end
            checks++; if (sin !== 32'h0) begin $display("FAIL reset_sin got %h exp 0", sin); errors++; end
            checks++; if (sc !== 5'd0) begin $display("FAIL reset_sc got %0d exp 0", sc); errors++; end
            checks++; if (pending !== 32'h0) begin $display("FAIL reset_pending got %h exp 0", pending); errors++; end
            checks++; if ({alu_ready, mem_ready} !== 2'b00) begin $display("FAIL reset_ready got %b exp 00", {alu_ready, mem_ready}); errors++; end
        end
        rstn = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b11) begin $display("FAIL release_ready got %b exp 11", {alu_ready, mem_ready}); errors++; end
        checks++; if (idle !== 1'b1) begin $display("FAIL release_idle got %b exp 1", idle); errors++; end
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'hAAAA_AAAA;
        #1;
        checks++; if (alu_ready !== 1'b1) begin $display("FAIL single_ready got %b exp 1", alu_ready); errors++; end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        checks++; if (sw !== 1'b0) begin $display("FAIL single_nobypass_sw got %b exp 0", sw); errors++; end
        checks++; if (pending !== 32'h0000_0020) begin $display("FAIL single_pending_queued got %h exp 00000020", pending); errors++; end
        @(posedge clk); #1;
        checks++; if (sw !== 1'b1) begin $display("FAIL single_sw got %b exp 1", sw); errors++; end
        checks++; if (sc !== 5'd5) begin $display("FAIL single_sc got %0d exp 5", sc); errors++; end
        checks++; if (sin !== 32'hAAAA_AAAA) begin $display("FAIL single_sin got %h exp aaaaaaaa", sin); errors++; end
        checks++; if (pending !== 32'h0000_0020) begin $display("FAIL single_pending_port got %h exp 00000020", pending); errors++; end
        @(posedge clk); #1;
        checks++; if (sw !== 1'b0) begin $display("FAIL single_sw_after got %b exp 0", sw); errors++; end
        checks++; if (sc !== 5'd5) begin $display("FAIL single_sc_hold got %0d exp 5", sc); errors++; end
        checks++; if (pending !== 32'h0) begin $display("FAIL single_pending_clear got %h exp 0", pending); errors++; end
        checks++; if (idle !== 1'b1) begin $display("FAIL single_idle got %b exp 1", idle); errors++; end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_sc;
        logic [W-1:0]  exp_sin;
        bit            drained;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        alu_valid = 1'b1; alu_dst = 5'd10; alu_data = 32'h5555_5555;
        mem_valid = 1'b1; mem_dst = 5'd5;  mem_data = 32'hAAAA_AAAA;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c >= 1) begin
                exp_sc  = (c % 2 == 1) ? 5'd10 : 5'd5;
                exp_sin = (c % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
                checks++; if (sw !== 1'b1) begin $display("FAIL rr_sw cycle %0d got %b exp 1", c, sw); errors++; end
                checks++; if (sc !== exp_sc) begin $display("FAIL rr_sc cycle %0d got %0d exp %0d", c, sc, exp_sc); errors++; end
                checks++; if (sin !== exp_sin) begin $display("FAIL rr_sin cycle %0d got %h exp %h", c, sin, exp_sin); errors++; end
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            @(posedge clk); #1;
            drained = idle;
        end
        checks++; if (!drained) begin $display("FAIL rr_drain got idle=%b exp 1 within 10 cycles", idle); errors++; end
        checks++; if (pending !== 32'h0) begin $display("FAIL rr_pending_clear got %h exp 0", pending); errors++; end
    endtask

    task automatic test_r0();
        alu_valid = 1'b1; alu_dst = 5'd0; alu_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        alu_valid = 1'b0;
        checks++; if (pending !== 32'h0) begin $display("FAIL r0_pending got %h exp 0", pending); errors++; end
        checks++; if (idle !== 1'b0) begin $display("FAIL r0_queued_idle got %b exp 0", idle); errors++; end
        @(posedge clk); #1;
        checks++; if (sw !== 1'b0) begin $display("FAIL r0_sw got %b exp 0", sw); errors++; end
        checks++; if (sc !== 5'd0) begin $display("FAIL r0_sc got %0d exp 0", sc); errors++; end
        checks++; if (sin !== 32'h0) begin $display("FAIL r0_sin got %h exp 0", sin); errors++; end
        checks++; if (idle !== 1'b1) begin $display("FAIL r0_idle got %b exp 1", idle); errors++; end
    endtask

    task automatic test_backpressure();
        int  ta, tm, ra, rm, occa, occm;
        bit  pa, pm, saw_full;
        ta = 1; tm = 1; ra = 0; rm = 0; occa = 0; occm = 0; saw_full = 1'b0;
        alu_dst = 5'd1; mem_dst = 5'd2;
        alu_valid = 1'b1; alu_data = 32'hA000_0001;
        mem_valid = 1'b1; mem_data = 32'hB000_0001;
        for (int c = 0; c < 60 && (ra < 8 || rm < 8); c++) begin
            #1;
            pa = alu_valid & alu_ready;
            pm = mem_valid & mem_ready;
            @(posedge clk); #1;
            if (sw === 1'b1) begin
                if (sc === 5'd1) begin
                    ra++; occa--;
                    checks++; if (sin !== (32'hA000_0000 | W'(ra))) begin $display("FAIL bp_alu_order got %h exp %h", sin, 32'hA000_0000 | W'(ra)); errors++; end
                end else if (sc === 5'd2) begin
                    rm++; occm--;
                    checks++; if (sin !== (32'hB000_0000 | W'(rm))) begin $display("FAIL bp_mem_order got %h exp %h", sin, 32'hB000_0000 | W'(rm)); errors++; end
                end else begin
                    checks++; errors++; $display("FAIL bp_sc got %0d exp 1 or 2", sc);
                end
            end
            if (pa) begin occa++; ta++; end
            if (pm) begin occm++; tm++; end
            alu_valid = (ta <= 8); alu_data = 32'hA000_0000 | W'(ta);
            mem_valid = (tm <= 8); mem_data = 32'hB000_0000 | W'(tm);
            #1;
            if (!alu_ready || !mem_ready) saw_full = 1'b1;
            checks++; if (alu_ready !== (occa < DEPTH)) begin $display("FAIL bp_alu_ready got %b exp %b occ %0d", alu_ready, occa < DEPTH, occa); errors++; end
            checks++; if (mem_ready !== (occm < DEPTH)) begin $display("FAIL bp_mem_ready got %b exp %b occ %0d", mem_ready, occm < DEPTH, occm); errors++; end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++; if (ra != 8) begin $display("FAIL bp_alu_count got %0d exp 8", ra); errors++; end
        checks++; if (rm != 8) begin $display("FAIL bp_mem_count got %0d exp 8", rm); errors++; end
        checks++; if (!saw_full) begin $display("FAIL bp_ready_low got 0 exp 1"); errors++; end
        @(posedge clk); #1;
        checks++; if (idle !== 1'b1) begin $display("FAIL bp_idle got %b exp 1", idle); errors++; end
    endtask

    task automatic test_reset_midop();
        alu_valid = 1'b1; alu_dst = 5'd7; alu_data = 32'hDEAD_0007;
        mem_valid = 1'b1; mem_dst = 5'd9; mem_data = 32'hBEEF_0009;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        checks++; if (pending !== 32'h0) begin $display("FAIL mid_pending_in_reset got %h exp 0", pending); errors++; end
        @(posedge clk); #1;
        checks++; if (sw !== 1'b0) begin $display("FAIL mid_sw_reset got %b exp 0", sw); errors++; end
        checks++; if ({alu_ready, mem_ready} !== 2'b00) begin $display("FAIL mid_ready got %b exp 00", {alu_ready, mem_ready}); errors++; end
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++; if (sw !== 1'b0) begin $display("FAIL mid_stale_sw cycle %0d got %b exp 0", c, sw); errors++; end
            checks++; if (pending !== 32'h0) begin $display("FAIL mid_pending cycle %0d got %h exp 0", c, pending); errors++; end
            checks++; if (idle !== 1'b1) begin $display("FAIL mid_idle cycle %0d got %b exp 1", c, idle); errors++; end
        end
    endtask

    initial begin
        rstn = 1'b0;
        alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dst = '0; mem_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_r0();
        test_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
